writeback_commit: RTL and testbench

//  Parametrised, registered writeback/commit stage closing the 5-stage pipeline; sits after memory.
//  - Accepts one instruction per cycle from memory over a valid/ready handshake.
//  - Arbitrates exceptions against NUM_IRQ prioritised interrupt lines and commits results to regfile/CSR.
//  - Runs a WFI sleep FSM that back-pressures memory until an interrupt wakes the core.

---
 rtl/writeback_commit.sv | 152 +++++++++++++++
 tb/tb_writeback_commit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_commit.sv
// ============================================================================
// Module   : writeback_commit
// Purpose  : Writeback/commit stage with trap arbitration and WFI sleep FSM.
//            Optional macro WB_INSTRET_EN enables the 64-bit instret counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_commit #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 3,
  parameter int CAUSE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    pc_in,
  input  logic [XLEN-1:0]    next_pc_in,
  input  logic [XLEN-1:0]    alu_data_in,
  input  logic [XLEN-1:0]    csr_data_in,
  input  logic [XLEN-1:0]    load_data_in,
  input  logic [1:0]         write_select_in,
  input  logic [4:0]         rd_address_in,
  input  logic [11:0]        csr_address_in,
  input  logic               csr_write_in,
  input  logic               mret_in,
  input  logic               wfi_in,
  input  logic               exception_in,
  input  logic [CAUSE_W-1:0] ecause_in,
  input  logic [NUM_IRQ-1:0] irq_pending,
  output logic [4:0]         rd_address,
  output logic [XLEN-1:0]    rd_data,
  output logic               csr_write,
  output logic [11:0]        csr_address,
  output logic [XLEN-1:0]    csr_data,
  output logic               traped,
  output logic               mret,
  output logic               retired,
  output logic [XLEN-1:0]    ecp,
  output logic [CAUSE_W-1:0] ecause,
  output logic               interupt,
  output logic               sleeping,
  output logic [63:0]        instret
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_SLEEP = 1'b1
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_wfi_pc;
  logic              w_accept;
  logic              w_irq_any;
  logic              w_trap;
  logic              w_wake;
  logic              w_retire;
  logic [CAUSE_W-1:0] w_irq_cause;
  logic [XLEN-1:0]   w_wb_data;

  assign in_ready  = (r_state == ST_RUN);
  assign sleeping  = (r_state == ST_SLEEP);
  assign w_accept  = in_valid && in_ready;
  assign w_irq_any = |irq_pending;
  assign w_trap    = w_accept && (w_irq_any || exception_in);
  assign w_wake    = sleeping && w_irq_any;
  assign w_retire  = w_accept && !w_trap;

  // Ascending scan so the highest-index pending line wins.
  always_comb begin
    w_irq_cause = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_pending[i]) w_irq_cause = CAUSE_W'(4 * i + 3);
    end
  end

  always_comb begin
    w_wb_data = alu_data_in;
    case (write_select_in)
      2'd0:    w_wb_data = alu_data_in;
      2'd1:    w_wb_data = csr_data_in;
      2'd2:    w_wb_data = load_data_in;
      default: w_wb_data = next_pc_in;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_wfi_pc    <= '0;
      rd_address  <= '0;
      rd_data     <= '0;
      csr_write   <= 1'b0;
      csr_address <= '0;
      csr_data    <= '0;
      traped      <= 1'b0;
      mret        <= 1'b0;
      retired     <= 1'b0;
      ecp         <= '0;
      ecause      <= '0;
      interupt    <= 1'b0;
    end else begin
      rd_address <= '0;
      csr_write  <= 1'b0;
      traped     <= 1'b0;
      mret       <= 1'b0;
      retired    <= 1'b0;
      if (w_trap) begin
        traped   <= 1'b1;
        interupt <= w_irq_any;
        ecause   <= w_irq_any ? w_irq_cause : ecause_in;
        ecp      <= wfi_in ? next_pc_in : pc_in;
      end else if (w_retire) begin
        retired     <= 1'b1;
        rd_address  <= rd_address_in;
        rd_data     <= w_wb_data;
        csr_write   <= csr_write_in;
        csr_address <= csr_address_in;
        csr_data    <= alu_data_in;
        mret        <= mret_in;
        if (wfi_in) begin
          r_wfi_pc <= next_pc_in;
          r_state  <= ST_SLEEP;
        end
      end else if (w_wake) begin
        traped   <= 1'b1;
        interupt <= 1'b1;
        ecause   <= w_irq_cause;
        ecp      <= r_wfi_pc;
        r_state  <= ST_RUN;
      end
    end
  end

`ifdef WB_INSTRET_EN
  logic [63:0] r_instret;

  // Counts on the same edge that raises the retired pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 64'd1;
  end

  assign instret = r_instret;
`else
  assign instret = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_commit.sv
// ============================================================================
// Module   : tb_writeback_commit
// Purpose  : Directed self-checking bench for writeback_commit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_commit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_in, next_pc_in, alu_data_in, csr_data_in, load_data_in;
  logic [1:0]  write_select_in;
  logic [4:0]  rd_address_in;
  logic [11:0] csr_address_in;
  logic        csr_write_in, mret_in, wfi_in, exception_in;
  logic [3:0]  ecause_in;
  logic [2:0]  irq_pending;
  logic [4:0]  rd_address;
  logic [31:0] rd_data;
  logic        csr_write;
  logic [11:0] csr_address;
  logic [31:0] csr_data;
  logic        traped, mret, retired;
  logic [31:0] ecp;
  logic [3:0]  ecause;
  logic        interupt, sleeping;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;
  longint unsigned exp_ret = 0;

  writeback_commit dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .next_pc_in(next_pc_in), .alu_data_in(alu_data_in),
    .csr_data_in(csr_data_in), .load_data_in(load_data_in),
    .write_select_in(write_select_in), .rd_address_in(rd_address_in),
    .csr_address_in(csr_address_in), .csr_write_in(csr_write_in),
    .mret_in(mret_in), .wfi_in(wfi_in), .exception_in(exception_in),
    .ecause_in(ecause_in), .irq_pending(irq_pending),
    .rd_address(rd_address), .rd_data(rd_data), .csr_write(csr_write),
    .csr_address(csr_address), .csr_data(csr_data), .traped(traped),
    .mret(mret), .retired(retired), .ecp(ecp), .ecause(ecause),
    .interupt(interupt), .sleeping(sleeping), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_instret();
`ifdef WB_INSTRET_EN
    return 64'(exp_ret);
`else
    return 64'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; pc_in = 0; next_pc_in = 0; alu_data_in = 0; csr_data_in = 0;
    load_data_in = 0; write_select_in = 0; rd_address_in = 0; csr_address_in = 0;
    csr_write_in = 0; mret_in = 0; wfi_in = 0; exception_in = 0; ecause_in = 0;
    irq_pending = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    tick(); tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (sleeping !== 1'b0) begin errors++; $display("FAIL reset_sleeping got %0b want 0", sleeping); end
    checks++; if ({rd_address, rd_data, csr_write, traped, mret, retired, ecp, ecause, interupt} !== '0)
      begin errors++; $display("FAIL reset_outputs got nonzero rd=%0h data=%0h ecp=%0h", rd_address, rd_data, ecp); end
    checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret got %0d want 0", instret); end
    reset_n = 1;
    exp_ret = 0;
    tick();
  endtask

  task automatic test_alu_retire();
    clear_inputs();
    in_valid = 1; pc_in = 32'h100; next_pc_in = 32'h104; alu_data_in = 32'hDEAD; rd_address_in = 5;
    tick();
    exp_ret++;
    clear_inputs();
    checks++; if (rd_address !== 5'd5) begin errors++; $display("FAIL alu_rd_address got %0d want 5", rd_address); end
    checks++; if (rd_data !== 32'hDEAD) begin errors++; $display("FAIL alu_rd_data got %0h want dead", rd_data); end
    checks++; if (retired !== 1'b1 || traped !== 1'b0) begin errors++; $display("FAIL alu_retired got ret=%0b trap=%0b want 1/0", retired, traped); end
    checks++; if (instret !== exp_instret()) begin errors++; $display("FAIL alu_instret got %0d want %0d", instret, exp_instret()); end
    tick();
    checks++; if (retired !== 1'b0 || rd_address !== 5'd0) begin errors++; $display("FAIL idle_pulses got ret=%0b rd=%0d want 0/0", retired, rd_address); end
    checks++; if (rd_data !== 32'hDEAD) begin errors++; $display("FAIL idle_hold got %0h want dead", rd_data); end
  endtask

  task automatic test_select();
    logic [31:0] want [4];
    want[0] = 32'h1111; want[1] = 32'h2222; want[2] = 32'h3333; want[3] = 32'h4444;
    for (int s = 0; s < 4; s++) begin
      clear_inputs();
      in_valid = 1; pc_in = 32'h500; next_pc_in = 32'h4444; alu_data_in = 32'h1111;
      csr_data_in = 32'h2222; load_data_in = 32'h3333; write_select_in = 2'(s);
      rd_address_in = 5'(s + 10); csr_address_in = 12'h305 + 12'(s);
      csr_write_in = (s == 1); mret_in = (s == 3);
      tick();
      exp_ret++;
      checks++; if (rd_data !== want[s]) begin errors++; $display("FAIL sel%0d_rd_data got %0h want %0h", s, rd_data, want[s]); end
      checks++; if (rd_address !== 5'(s + 10)) begin errors++; $display("FAIL sel%0d_rd_address got %0d want %0d", s, rd_address, s + 10); end
      checks++; if (csr_write !== (s == 1) || csr_address !== 12'h305 + 12'(s) || csr_data !== 32'h1111)
        begin errors++; $display("FAIL sel%0d_csr got we=%0b a=%0h d=%0h", s, csr_write, csr_address, csr_data); end
      checks++; if (mret !== (s == 3)) begin errors++; $display("FAIL sel%0d_mret got %0b want %0b", s, mret, s == 3); end
    end
    clear_inputs();
    tick();
    checks++; if (instret !== exp_instret()) begin errors++; $display("FAIL sel_instret got %0d want %0d", instret, exp_instret()); end
  endtask

  task automatic test_exception();
    clear_inputs();
    in_valid = 1; exception_in = 1; ecause_in = 2; pc_in = 32'h200; next_pc_in = 32'h204;
    rd_address_in = 7; csr_write_in = 1; mret_in = 1;
    tick();
    clear_inputs();
    checks++; if (traped !== 1'b1 || interupt !== 1'b0 || ecause !== 4'd2)
      begin errors++; $display("FAIL exc_cause got trap=%0b int=%0b cause=%0d want 1/0/2", traped, interupt, ecause); end
    checks++; if (ecp !== 32'h200) begin errors++; $display("FAIL exc_ecp got %0h want 200", ecp); end
    checks++; if (rd_address !== 0 || retired !== 0 || csr_write !== 0 || mret !== 0)
      begin errors++; $display("FAIL exc_suppress got rd=%0d ret=%0b we=%0b mret=%0b want 0", rd_address, retired, csr_write, mret); end
    tick();
    checks++; if (traped !== 1'b0) begin errors++; $display("FAIL exc_pulse got %0b want 0", traped); end
  endtask

  task automatic test_priority();
    logic [2:0] irqs [3];
    logic [3:0] cause [3];
    irqs[0] = 3'b011; cause[0] = 4'd7;
    irqs[1] = 3'b111; cause[1] = 4'd11;
    irqs[2] = 3'b001; cause[2] = 4'd3;
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      in_valid = 1; irq_pending = irqs[k]; exception_in = 1; ecause_in = 4'd2;
      csr_write_in = 1; pc_in = 32'h600 + 32'(k * 4); next_pc_in = 32'h700;
      tick();
      checks++; if (ecause !== cause[k] || interupt !== 1'b1 || traped !== 1'b1)
        begin errors++; $display("FAIL prio%0d got cause=%0d int=%0b trap=%0b want %0d/1/1", k, ecause, interupt, traped, cause[k]); end
      checks++; if (csr_write !== 1'b0 || ecp !== 32'h600 + 32'(k * 4))
        begin errors++; $display("FAIL prio%0d_side got we=%0b ecp=%0h", k, csr_write, ecp); end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_wfi_sleep();
    clear_inputs();
    in_valid = 1; wfi_in = 1; pc_in = 32'h300; next_pc_in = 32'h304; rd_address_in = 0;
    tick();
    exp_ret++;
    checks++; if (retired !== 1'b1 || traped !== 1'b0) begin errors++; $display("FAIL wfi_retire got ret=%0b trap=%0b want 1/0", retired, traped); end
    clear_inputs();
    in_valid = 1; pc_in = 32'h308; rd_address_in = 9; alu_data_in = 32'hBAD;
    repeat (5) tick();
    checks++; if (in_ready !== 1'b0 || sleeping !== 1'b1) begin errors++; $display("FAIL wfi_sleep got rdy=%0b slp=%0b want 0/1", in_ready, sleeping); end
    checks++; if (retired !== 1'b0 || rd_address !== 5'd0) begin errors++; $display("FAIL wfi_backpressure got ret=%0b rd=%0d want 0/0", retired, rd_address); end
    clear_inputs();
    irq_pending = 3'b100;
    tick();
    irq_pending = 0;
    checks++; if (traped !== 1'b1 || interupt !== 1'b1 || ecause !== 4'd11 || retired !== 1'b0)
      begin errors++; $display("FAIL wfi_wake got trap=%0b int=%0b cause=%0d ret=%0b", traped, interupt, ecause, retired); end
    checks++; if (ecp !== 32'h304) begin errors++; $display("FAIL wfi_ecp got %0h want 304", ecp); end
    checks++; if (in_ready !== 1'b1 || sleeping !== 1'b0) begin errors++; $display("FAIL wfi_run got rdy=%0b slp=%0b want 1/0", in_ready, sleeping); end
    tick();
    checks++; if (instret !== exp_instret()) begin errors++; $display("FAIL wfi_instret got %0d want %0d", instret, exp_instret()); end
  endtask

  task automatic test_simultaneous();
    clear_inputs();
    in_valid = 1; wfi_in = 1; irq_pending = 3'b001; pc_in = 32'h400; next_pc_in = 32'h404;
    tick();
    clear_inputs();
    checks++; if (traped !== 1'b1 || ecause !== 4'd3 || interupt !== 1'b1 || retired !== 1'b0)
      begin errors++; $display("FAIL simul_trap got trap=%0b cause=%0d int=%0b ret=%0b", traped, ecause, interupt, retired); end
    checks++; if (ecp !== 32'h404) begin errors++; $display("FAIL simul_ecp got %0h want 404", ecp); end
    checks++; if (sleeping !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL simul_nosleep got slp=%0b rdy=%0b want 0/1", sleeping, in_ready); end
    tick();
    checks++; if (sleeping !== 1'b0) begin errors++; $display("FAIL simul_stay_run got %0b want 0", sleeping); end
  endtask

  task automatic test_reset_in_sleep();
    clear_inputs();
    in_valid = 1; wfi_in = 1; pc_in = 32'h800; next_pc_in = 32'h804; rd_address_in = 3; alu_data_in = 32'h77;
    tick();
    clear_inputs();
    checks++; if (sleeping !== 1'b1 || retired !== 1'b1) begin errors++; $display("FAIL rst_pre got slp=%0b ret=%0b want 1/1", sleeping, retired); end
    #2;
    reset_n = 0;
    #1;
    exp_ret = 0;
    checks++; if (sleeping !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_async got slp=%0b rdy=%0b want 0/1", sleeping, in_ready); end
    checks++; if ({rd_address, rd_data, csr_write, traped, mret, retired, ecp, ecause, interupt} !== '0)
      begin errors++; $display("FAIL rst_outputs got rd=%0d data=%0h ret=%0b", rd_address, rd_data, retired); end
    checks++; if (instret !== 64'd0) begin errors++; $display("FAIL rst_instret got %0d want 0", instret); end
    tick();
    reset_n = 1;
    tick();
    checks++; if (sleeping !== 1'b0 || retired !== 1'b0) begin errors++; $display("FAIL rst_after got slp=%0b ret=%0b want 0/0", sleeping, retired); end
  endtask

  initial begin
    reset_n = 0;
    clear_inputs();
    test_reset();
    test_alu_retire();
    test_select();
    test_exception();
    test_priority();
    test_wfi_sleep();
    test_simultaneous();
    test_reset_in_sleep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
